ladybird_trap_ctrl: RTL
=======================

# ladybird_trap_ctrl

Trap and MRET sequencer that owns the single CSR-file access port and arbitrates it between instruction-level CSR accesses and multi-cycle trap-entry/trap-return sequences. It sits directly upstream of the CSR file: it drives op/valid/addr/data and reads back the CSR file's combinational read data. It returns a registered redirect PC to fetch. Width is XLEN from `ladybird_config`. CSR op encodings come from `ladybird_riscv_helper`.

## Interface
- `VEC_SHIFT`, default 2: log2 byte spacing of vectored-mode entries.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `i_csr_valid` in 1: instruction CSR request.
- `o_csr_ready` out 1: request accepted this cycle.
- `i_csr_op` in 3: funct3.
- `i_csr_addr` in 12: CSR address.
- `i_csr_data` in XLEN: rs1 or zimm operand.
- `o_csr_rvalid` out 1: one-cycle pulse carrying the old CSR value.
- `o_csr_rdata` out XLEN: old CSR value.
- `i_trap_valid` in 1: exception or interrupt request; held until accepted.
- `i_trap_cause` in XLEN: mcause value; bit XLEN-1 is the interrupt flag.
- `i_trap_pc` in XLEN: faulting PC.
- `i_trap_tval` in XLEN: mtval value.
- `i_mret_valid` in 1: MRET request; held until accepted.
- `o_ready` out 1: trap or MRET accepted this cycle.
- `o_redirect_valid` out 1: one-cycle redirect pulse.
- `o_redirect_pc` out XLEN: redirect target.
- `o_busy` out 1: FSM not IDLE.
- `o_op` out 3, `o_valid` out 1, `o_addr` out 12, `o_data` out XLEN: CSR-file port.
- `i_data` in XLEN: CSR-file combinational read data for `o_addr`.

## Operation
- States: IDLE, EPC, CAUSE, TVAL, STATUS, VEC, MSTAT, MEPC.
- Arbitration in IDLE, priority trap > MRET > instruction CSR.
  - Trap accepted when `i_trap_valid`: `o_ready`=1; cause, pc and tval are latched; next state EPC.
  - MRET accepted when `i_mret_valid & ~i_trap_valid`: `o_ready`=1; next state MSTAT.
  - Otherwise the instruction path is a combinational pass-through: `o_csr_ready`=1; `o_valid`=`i_csr_valid`; op, addr and data are forwarded.
  - On an accepted request, `o_csr_rdata`<=`i_data` and `o_csr_rvalid` pulses the next cycle.
- In every non-IDLE state, and on any IDLE cycle where a trap or MRET wins, `o_csr_ready`=0 and no instruction access reaches the CSR file.
- Trap sequence, one access per state, all CSRRW with `o_valid`=1:
  - EPC: write 0x341 = pc & ~3.
  - CAUSE: write 0x342 = cause.
  - TVAL: write 0x343 = tval.
  - STATUS: addr 0x300, single-cycle read-modify-write of `i_data`: MPIE<=MIE, MIE<=0, MPP<=2'b11, all other bits unchanged.
  - VEC: addr 0x305 with `o_valid`=0, read only. Target = {mtvec[XLEN-1:2],2'b00}, adjusted per Configuration.
- MRET sequence:
  - MSTAT: RMW 0x300: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - MEPC: read 0x341 with `o_valid`=0; target = `i_data` & ~3.
- VEC and MEPC register the target into `o_redirect_pc`, set `o_redirect_valid`, and return to IDLE.
- Arithmetic is modulo 2^XLEN; the vector offset wraps silently.
- When idle and not forwarding, port outputs are `o_valid`=0, `o_op`=CSRRW, `o_addr`=0, `o_data`=0.

## Timing
- Trap accepted in cycle 0. CSR writes in cycles 1–4, mtvec read in cycle 5, `o_redirect_valid` high in cycle 6. IDLE in cycle 6, so a new request can be accepted in cycle 6.
- MRET accepted in cycle 0. mstatus write in cycle 1, mepc read in cycle 2, redirect in cycle 3.
- Instruction CSR read data arrives one cycle after acceptance; there are no back-to-back restrictions while IDLE.
- `o_ready`, `o_csr_ready`, `o_valid` and `o_busy` are combinational from state and requests. Redirect and rdata outputs are registered.
- Reset values: state IDLE; `o_redirect_valid`=0, `o_redirect_pc`=0, `o_csr_rvalid`=0, `o_csr_rdata`=0; latched trap fields 0.
- Reset asserted mid-sequence: immediately IDLE, no further CSR accesses, no redirect pulse. CSRs already written keep their values; this block does not roll them back.
- A trap arriving while busy waits (`o_ready`=0) and is accepted on the redirect cycle.

## Configuration
- `LADYBIRD_TRAP_VECTORED_EN` defined: if mtvec[1:0]==2'b01 and cause[XLEN-1]==1, target = base + (cause[XLEN-2:0] << VEC_SHIFT).
- Undefined: target is always base, regardless of mtvec mode or cause type. Latency is identical either way.

## Test plan
- Instruction CSR: CSRRW 0x305 data 0x80000100 in IDLE -> `o_valid`=1 same cycle; next cycle `o_csr_rvalid`=1 with the prior mtvec (0 after reset).
- Trap: mtvec=0x80000100, mstatus.MIE=1, cause=2, pc=0x80000046, tval=0xdeadbeef -> writes mepc 0x80000044, mcause 2, mtval 0xdeadbeef; mstatus MIE=0, MPIE=1, MPP=3; redirect 0x80000100 in cycle 6.
- Vectored (macro on): mtvec=0x80000101, cause=0x80000007 -> redirect 0x8000011c. Macro off -> redirect 0x80000100.
- MRET: mstatus MPIE=1, MIE=0, mepc=0x80000200 -> MIE=1, MPIE=1; redirect 0x80000200 in cycle 3.
- Contention: trap, MRET and CSR valid in the same cycle -> trap accepted; `o_csr_ready`=0 for cycles 0–5. MRET is accepted in cycle 6, and the CSR request is accepted once no trap or MRET is pending.
- Reset asserted in cycle 3 of a trap sequence -> `o_busy`=0 and no redirect pulse; mepc and mcause retain the values written.

Source files
------------

// File: rtl/ladybird_trap_ctrl.sv
// ladybird_trap_ctrl: trap-entry / MRET sequencer that owns the CSR-file port.
// Define LADYBIRD_TRAP_VECTORED_EN to enable vectored interrupt targets.

package ladybird_config;
    localparam int XLEN = 32;
endpackage

package ladybird_riscv_helper;
    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;
endpackage

module ladybird_trap_ctrl
    import ladybird_config::*;
    import ladybird_riscv_helper::*;
#(
    parameter int VEC_SHIFT = 2
) (
    input  logic            clk,
    input  logic            nrst,

    input  logic            i_csr_valid,
    output logic            o_csr_ready,
    input  logic [2:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_data,
    output logic            o_csr_rvalid,
    output logic [XLEN-1:0] o_csr_rdata,

    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_mret_valid,
    output logic            o_ready,

    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy,

    output logic [2:0]      o_op,
    output logic            o_valid,
    output logic [11:0]     o_addr,
    output logic [XLEN-1:0] o_data,
    input  logic [XLEN-1:0] i_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EPC    = 3'd1,
        S_CAUSE  = 3'd2,
        S_TVAL   = 3'd3,
        S_STATUS = 3'd4,
        S_VEC    = 3'd5,
        S_MSTAT  = 3'd6,
        S_MEPC   = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;

    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            idle;
    logic            take_trap;
    logic            take_mret;
    logic            take_csr;

    logic [XLEN-1:0] status_trap;
    logic [XLEN-1:0] status_mret;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic [XLEN-1:0] vec_target;
    logic [XLEN-1:0] mepc_target;
    logic            vec_sel;

    assign idle      = (state_q == S_IDLE);
    assign take_trap = idle & i_trap_valid;
    assign take_mret = idle & i_mret_valid & ~i_trap_valid;
    assign take_csr  = idle & ~i_trap_valid & ~i_mret_valid & i_csr_valid;

    // Trap entry: stack MIE into MPIE, disable interrupts, enter M-mode.
    always_comb begin
        status_trap = i_data;
        status_trap[MSTATUS_MPIE] = i_data[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]  = 1'b0;
        status_trap[MSTATUS_MPP +: 2] = 2'b11;
    end

    always_comb begin
        status_mret = i_data;
        status_mret[MSTATUS_MIE]  = i_data[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE] = 1'b1;
        status_mret[MSTATUS_MPP +: 2] = 2'b11;
    end

    assign vec_base    = {i_data[XLEN-1:2], 2'b00};
    assign vec_off     = {1'b0, cause_q[XLEN-2:0]} << VEC_SHIFT;
    assign mepc_target = {i_data[XLEN-1:2], 2'b00};

`ifdef LADYBIRD_TRAP_VECTORED_EN
    assign vec_sel = (i_data[1:0] == 2'b01) & cause_q[XLEN-1];
`else
    assign vec_sel = 1'b0;
`endif

    // Offset wraps modulo 2^XLEN by construction.
    assign vec_target = vec_base + (vec_sel ? vec_off : '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_trap_valid) begin
                    state_d = S_EPC;
                end else if (i_mret_valid) begin
                    state_d = S_MSTAT;
                end
            end
            S_EPC:    state_d = S_CAUSE;
            S_CAUSE:  state_d = S_TVAL;
            S_TVAL:   state_d = S_STATUS;
            S_STATUS: state_d = S_VEC;
            S_VEC:    state_d = S_IDLE;
            S_MSTAT:  state_d = S_MEPC;
            S_MEPC:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = 1'b0;
        o_csr_ready = 1'b0;
        o_busy      = ~idle;
        o_valid     = 1'b0;
        o_op        = CSR_RW;
        o_addr      = '0;
        o_data      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_trap_valid || i_mret_valid) begin
                    o_ready = 1'b1;
                end else begin
                    o_csr_ready = 1'b1;
                    if (i_csr_valid) begin
                        o_valid = 1'b1;
                        o_op    = i_csr_op;
                        o_addr  = i_csr_addr;
                        o_data  = i_csr_data;
                    end
                end
            end
            S_EPC: begin
                o_valid = 1'b1;
                o_addr  = CSR_MEPC;
                o_data  = {pc_q[XLEN-1:2], 2'b00};
            end
            S_CAUSE: begin
                o_valid = 1'b1;
                o_addr  = CSR_MCAUSE;
                o_data  = cause_q;
            end
            S_TVAL: begin
                o_valid = 1'b1;
                o_addr  = CSR_MTVAL;
                o_data  = tval_q;
            end
            S_STATUS: begin
                o_valid = 1'b1;
                o_addr  = CSR_MSTATUS;
                o_data  = status_trap;
            end
            S_VEC: begin
                o_addr = CSR_MTVEC;
            end
            S_MSTAT: begin
                o_valid = 1'b1;
                o_addr  = CSR_MSTATUS;
                o_data  = status_mret;
            end
            S_MEPC: begin
                o_addr = CSR_MEPC;
            end
        endcase
    end

    always_comb begin
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        if (take_trap) begin
            cause_d = i_trap_cause;
            pc_d    = i_trap_pc;
            tval_d  = i_trap_tval;
        end
    end

    always_comb begin
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        if (state_q == S_VEC) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = vec_target;
        end else if (state_q == S_MEPC) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = mepc_target;
        end
    end

    always_comb begin
        rvalid_d = take_csr;
        rdata_d  = take_csr ? i_data : rdata_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cause_q       <= '0;
            pc_q          <= '0;
            tval_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            cause_q       <= cause_d;
            pc_q          <= pc_d;
            tval_q        <= tval_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign o_redirect_valid = redir_valid_q;
    assign o_redirect_pc    = redir_pc_q;
    assign o_csr_rvalid     = rvalid_q;
    assign o_csr_rdata      = rdata_q;

endmodule
